// File: rtl/split_signal_master.sv
// Host-side initiator for a split_signal data selector: sequences one request at a
// time onto the registered command bus and returns one response per bus access.
module split_signal_master #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [ADR_W-1:0]  req_adr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [ADR_W-1:0]  rsp_adr_o,
    output logic              rsp_last_o,
    output logic              rsp_err_o,
    output logic              bus_read_sig_o,
    output logic              bus_write_sig_o,
    output logic [ADR_W-1:0]  bus_adr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i
);

    localparam logic [2:0]       OP_IDLE   = 3'b000;
    localparam logic [2:0]       OP_READ   = 3'b001;
    localparam logic [2:0]       OP_WRITE  = 3'b010;
    localparam logic [2:0]       OP_DIRECT = 3'b011;
    localparam logic [2:0]       OP_DUMP   = 3'b100;
    localparam logic [ADR_W-1:0] LAST_ADR  = '1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_CAP, S_RSP} state_t;

    state_t             state, state_next;
    logic [2:0]         op_q, op_next;
    logic [ADR_W-1:0]   cnt, cnt_next;
    logic               rd_next, wr_next;
    logic [ADR_W-1:0]   bus_adr_next;
    logic [DATA_W-1:0]  bus_data_next;
    logic [DATA_W-1:0]  rsp_data_next;
    logic [ADR_W-1:0]   rsp_adr_next;
    logic               rsp_last_next, rsp_err_next;

    // {read_sig, write_sig} encoding as the slave decodes it; DUMP is a sequence of reads.
    function automatic logic [1:0] bus_enc(input logic [2:0] op);
        case (op)
            OP_READ, OP_DUMP: bus_enc = 2'b01;
            OP_WRITE:         bus_enc = 2'b10;
            OP_DIRECT:        bus_enc = 2'b11;
            default:          bus_enc = 2'b00;
        endcase
    endfunction

    always_comb begin
        state_next    = state;
        op_next       = op_q;
        cnt_next      = cnt;
        rd_next       = 1'b0;
        wr_next       = 1'b0;
        bus_adr_next  = bus_adr_o;
        bus_data_next = bus_data_o;
        rsp_data_next = rsp_data_o;
        rsp_adr_next  = rsp_adr_o;
        rsp_last_next = rsp_last_o;
        rsp_err_next  = rsp_err_o;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_next = req_op_i;
                    if (req_op_i != OP_IDLE && req_op_i <= OP_DUMP) begin
                        state_next         = S_CMD;
                        {rd_next, wr_next} = bus_enc(req_op_i);
                        bus_adr_next       = (req_op_i == OP_DUMP) ? cnt : req_adr_i;
                        bus_data_next      = (req_op_i == OP_WRITE || req_op_i == OP_DIRECT)
                                             ? req_data_i : '0;
                    end else begin
                        // IDLE and illegal ops answer directly without touching the bus
                        state_next    = S_RSP;
                        rsp_data_next = '0;
                        rsp_adr_next  = req_adr_i;
                        rsp_last_next = 1'b1;
                        rsp_err_next  = (req_op_i != OP_IDLE);
                    end
                end
            end
            S_CMD: state_next = S_CAP;
            S_CAP: begin
                state_next    = S_RSP;
                rsp_data_next = bus_data_i;
                rsp_adr_next  = bus_adr_o;
                rsp_last_next = (op_q != OP_DUMP) || (cnt == LAST_ADR);
                rsp_err_next  = 1'b0;
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    if (op_q == OP_DUMP && cnt != LAST_ADR) begin
                        state_next         = S_CMD;
                        cnt_next           = cnt + 1'b1;
                        {rd_next, wr_next} = bus_enc(OP_DUMP);
                        bus_adr_next       = cnt + 1'b1;
                        bus_data_next      = '0;
                    end else begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= S_IDLE;
            op_q            <= OP_IDLE;
            cnt             <= '0;
            bus_read_sig_o  <= 1'b0;
            bus_write_sig_o <= 1'b0;
            bus_adr_o       <= '0;
            bus_data_o      <= '0;
            rsp_data_o      <= '0;
            rsp_adr_o       <= '0;
            rsp_last_o      <= 1'b0;
            rsp_err_o       <= 1'b0;
        end else begin
            state           <= state_next;
            op_q            <= op_next;
            cnt             <= cnt_next;
            bus_read_sig_o  <= rd_next;
            bus_write_sig_o <= wr_next;
            bus_adr_o       <= bus_adr_next;
            bus_data_o      <= bus_data_next;
            rsp_data_o      <= rsp_data_next;
            rsp_adr_o       <= rsp_adr_next;
            rsp_last_o      <= rsp_last_next;
            rsp_err_o       <= rsp_err_next;
        end
    end

    assign req_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RSP);

endmodule

// File: tb/tb_split_signal_master.sv
// Bench for split_signal_master: a slave model on the bus, a request-level reference
// model producing expected bus cycles and responses, and one per-cycle compare process.
module tb_split_signal_master;
    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_adr, rsp_adr, bus_adr;
    logic [DW-1:0] req_data, rsp_data, bus_dout, bus_din;
    logic          rsp_last, rsp_err, bus_rd, bus_wr;

    always #5 clk = ~clk;

    split_signal_master #(.DATA_W(DW), .ADR_W(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_adr_i(req_adr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_adr_o(rsp_adr), .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
        .bus_read_sig_o(bus_rd), .bus_write_sig_o(bus_wr), .bus_adr_o(bus_adr),
        .bus_data_o(bus_dout), .bus_data_i(bus_din)
    );

    // split_signal-class slave: registered output, cells survive master reset
    logic [DW-1:0] cells [4] = '{default: '0};
    logic [DW-1:0] slv_q = '0;
    always @(posedge clk) begin
        case ({bus_rd, bus_wr})
            2'b01: slv_q <= cells[bus_adr];
            2'b10: begin cells[bus_adr] <= bus_dout; slv_q <= '0; end
            2'b11: slv_q <= (bus_dout != 0) ? bus_dout : 8'd64;
            default: ;
        endcase
    end
    assign bus_din = slv_q;

    typedef struct { logic [DW-1:0] data; logic [AW-1:0] adr; logic last; logic err; } rsp_t;
    typedef struct { logic [1:0] cmd; logic [AW-1:0] adr; logic [DW-1:0] data; } bus_t;

    rsp_t          rsp_q[$];
    bus_t          bus_q[$];
    logic [DW-1:0] mem [4] = '{default: '0};
    int            checks = 0, errors = 0;
    int            n_rsp = 0;
    logic [DW-1:0] last_data;
    logic [AW-1:0] last_adr;
    logic          last_last, last_err;
    int            rdy_mode = 0, stall_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what a request must do, expressed as bus cycles and responses.
    task automatic model_req(input logic [2:0] op, input logic [AW-1:0] adr, input logic [DW-1:0] d);
        rsp_t r;
        bus_t b;
        r.err = 1'b0; r.last = 1'b1; r.adr = adr; r.data = '0;
        b.adr = adr; b.data = '0;
        case (op)
            3'd0: rsp_q.push_back(r);
            3'd1: begin b.cmd = 2'b01; r.data = mem[adr]; bus_q.push_back(b); rsp_q.push_back(r); end
            3'd2: begin b.cmd = 2'b10; b.data = d; mem[adr] = d; bus_q.push_back(b); rsp_q.push_back(r); end
            3'd3: begin b.cmd = 2'b11; b.data = d; r.data = (d != 0) ? d : 8'd64;
                        bus_q.push_back(b); rsp_q.push_back(r); end
            3'd4: for (int i = 0; i < 4; i++) begin
                      b.cmd = 2'b01; b.adr = AW'(i); bus_q.push_back(b);
                      r.adr = AW'(i); r.data = mem[i]; r.last = (i == 3); rsp_q.push_back(r);
                  end
            default: begin r.err = 1'b1; rsp_q.push_back(r); end
        endcase
    endtask

    // Compare process
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_adr;
    logic          prev_last, prev_err;
    rsp_t          er;
    bus_t          eb;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if ({bus_rd, bus_wr} != 2'b00) begin
                chk("bus_expected", bus_q.size() != 0, 1);
                chk("bus_req_ready", req_ready, 0);
                if (bus_q.size() != 0) begin
                    eb = bus_q.pop_front();
                    chk("bus_cmd", {bus_rd, bus_wr}, eb.cmd);
                    chk("bus_adr", bus_adr, eb.adr);
                    chk("bus_data", bus_dout, eb.data);
                end
            end
            if (rsp_valid) begin
                chk("rsp_bus_idle", {bus_rd, bus_wr}, 2'b00);
                chk("rsp_req_ready", req_ready, 0);
                if (prev_stall) begin
                    chk("hold_data", rsp_data, prev_data);
                    chk("hold_adr", rsp_adr, prev_adr);
                    chk("hold_last", rsp_last, prev_last);
                    chk("hold_err", rsp_err, prev_err);
                end
                if (rsp_ready) begin
                    chk("rsp_expected", rsp_q.size() != 0, 1);
                    if (rsp_q.size() != 0) begin
                        er = rsp_q.pop_front();
                        chk("rsp_data", rsp_data, er.data);
                        chk("rsp_adr", rsp_adr, er.adr);
                        chk("rsp_last", rsp_last, er.last);
                        chk("rsp_err", rsp_err, er.err);
                    end
                    last_data = rsp_data; last_adr = rsp_adr;
                    last_last = rsp_last; last_err = rsp_err;
                    n_rsp++;
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data = rsp_data; prev_adr = rsp_adr; prev_last = rsp_last; prev_err = rsp_err;
        end
    end

    // Response-side host: always ready, random, or a 5-cycle stall on the adr-1 response
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ($urandom_range(0, 2) != 0);
                default:
                    if (rsp_valid && rsp_adr == 2'd1 && stall_cnt < 5) begin
                        rsp_ready = 1'b0;
                        stall_cnt++;
                    end else rsp_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [2:0] op, input logic [AW-1:0] adr, input logic [DW-1:0] d,
                        input bit use_model);
        int n = 0;
        if (use_model) model_req(op, adr, d);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_adr = adr; req_data = d;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk("accept_timeout", n < 200, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!(rsp_q.size() == 0 && bus_q.size() == 0 && req_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 400, 1);
    endtask

    initial begin
        int base;
        req_valid = 1'b0; req_op = '0; req_adr = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_bus", {bus_rd, bus_wr, bus_adr, bus_dout}, 0);
        chk("rst_rsp", {rsp_data, rsp_adr, rsp_last, rsp_err}, 0);
        rst_n = 1'b1;

        // Reset during the CMD cycle of a WRITE: aborted, nothing reaches the slave
        send(3'd2, 2'd1, 8'h99, 1'b0);
        chk("abort_cmd_seen", {bus_rd, bus_wr}, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_bus_zero", {bus_rd, bus_wr, bus_adr, bus_dout}, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_req_ready", req_ready, 1);
        repeat (6) begin @(negedge clk); chk("abort_no_rsp", rsp_valid, 0); end

        // WRITE then READ with latency pinned
        send(3'd2, 2'd2, 8'hA5, 1'b1);
        wait_done();
        chk("wr_rsp_data", last_data, 8'h00);
        chk("wr_rsp_adr", last_adr, 2'd2);
        chk("wr_rsp_last", last_last, 1);
        send(3'd1, 2'd2, 8'h00, 1'b1);
        @(negedge clk);
        chk("rd_lat_cmd", {bus_rd, bus_wr}, 2'b01);
        chk("rd_lat_v0", rsp_valid, 0);
        @(negedge clk);
        chk("rd_lat_cap", {bus_rd, bus_wr}, 2'b00);
        chk("rd_lat_v1", rsp_valid, 0);
        @(negedge clk);
        chk("rd_lat_v2", rsp_valid, 1);
        wait_done();
        chk("rd_rsp_data", last_data, 8'hA5);
        chk("abort_cell1", cells[1], 8'h00);

        // DIRECT, including the zero-payload substitution done by the slave
        send(3'd3, 2'd0, 8'h3C, 1'b1);
        wait_done();
        chk("direct_3c", last_data, 8'h3C);
        send(3'd3, 2'd0, 8'h00, 1'b1);
        wait_done();
        chk("direct_zero", last_data, 8'h40);

        // Fill and DUMP
        for (int i = 0; i < 4; i++) send(3'd2, AW'(i), DW'(8'h11 * (i + 1)), 1'b1);
        wait_done();
        base = n_rsp;
        send(3'd4, 2'd3, 8'hFF, 1'b1);
        wait_done();
        chk("dump_count", n_rsp - base, 4);
        chk("dump_last_adr", last_adr, 2'd3);
        chk("dump_last_data", last_data, 8'h44);
        chk("dump_last_flag", last_last, 1);

        // DUMP with the second response stalled for 5 cycles
        stall_cnt = 0; rdy_mode = 2;
        base = n_rsp;
        send(3'd4, 2'd0, 8'h00, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!(rsp_valid && !rsp_ready) && n < 50) begin @(negedge clk); n++; end
            chk("bp_found", n < 50, 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", rsp_data, 8'h22);
            chk("bp_bus", {bus_rd, bus_wr}, 2'b00);
            chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        wait_done();
        rdy_mode = 0;
        chk("bp_count", n_rsp - base, 4);
        chk("bp_last_data", last_data, 8'h44);

        // Illegal opcode
        send(3'b110, 2'd1, 8'h5A, 1'b1);
        wait_done();
        chk("ill_err", last_err, 1);
        chk("ill_data", last_data, 8'h00);
        chk("ill_last", last_last, 1);

        // Randomized traffic with random response back-pressure
        rdy_mode = 1;
        repeat (80) begin
            logic [2:0]    op;
            logic [DW-1:0] d;
            op = 3'($urandom_range(0, 7));
            d  = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom);
            send(op, AW'($urandom), d, 1'b1);
        end
        wait_done();
        rdy_mode = 0;
        chk("final_rsp_q_empty", rsp_q.size(), 0);
        chk("final_bus_q_empty", bus_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/split_signal_master.md
Name: split_signal_master

Overview:
- Initiator for the split_signal command bus: {read_sig, write_sig}, adr, data out; registered data back.
- Accepts requests from a host over a valid/ready interface, sequences each onto the bus with the correct slave latency, and returns exactly one response per bus access.
- Adds a DUMP operation that reads all cells back-to-back.
- Sits between host/control logic and one split_signal-class data selector.

Parameters:
DATA_W, 8, width of data on host and bus sides
ADR_W, 2, address width; cell count = 2**ADR_W

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  asynchronous, active-low reset
req_valid_i  input  1  host request valid
req_ready_o  output  1  master can accept a request
req_op_i  input  3  000 IDLE, 001 READ, 010 WRITE, 011 DIRECT, 100 DUMP, others illegal
req_adr_i  input  ADR_W  target cell (ignored for DIRECT, DUMP)
req_data_i  input  DATA_W  write data or DIRECT payload
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  host accepts response
rsp_data_o  output  DATA_W  captured bus data
rsp_adr_o  output  ADR_W  address this response belongs to
rsp_last_o  output  1  final response of the request
rsp_err_o  output  1  illegal opcode
bus_read_sig_o  output  1  slave read_sig
bus_write_sig_o  output  1  slave write_sig
bus_adr_o  output  ADR_W  slave address
bus_data_o  output  DATA_W  slave data input
bus_data_i  input  DATA_W  slave registered data output

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; req_ready_o=1; rsp_valid_o, rsp_last_o, rsp_err_o=0; rsp_data_o, rsp_adr_o=0; all bus outputs 0 ({read,write}=00). The cell counter is cleared. Reset mid-operation aborts the request with no response.
- Bus encoding, {bus_read_sig_o, bus_write_sig_o}:
  - READ = 01
  - WRITE = 10
  - DIRECT = 11
  - 00 in every cycle not in CMD
- All bus outputs are registered.
- FSM states: IDLE, CMD, CAP, RSP.
- IDLE:
  - req_ready_o=1.
  - Handshake (req_valid_i & req_ready_o) latches op, adr, data.
  - Legal non-IDLE op -> CMD.
  - IDLE op (000) -> RSP with rsp_data_o=0, no bus activity.
  - Illegal op -> RSP with rsp_err_o=1, rsp_data_o=0, no bus activity.
- CMD (1 cycle):
  - Bus driven with the latched command.
  - bus_adr_o = latched adr (DUMP: counter value).
  - bus_data_o = latched data (0 for READ/DUMP).
  - -> CAP.
- CAP (1 cycle): bus back to 00. At the closing edge, bus_data_i is captured into rsp_data_o and bus_adr_o into rsp_adr_o; -> RSP.
- RSP:
  - rsp_valid_o=1; rsp_data_o, rsp_adr_o, rsp_last_o, rsp_err_o are held stable until rsp_ready_i=1.
  - On handshake, DUMP with counter < 2**ADR_W-1: increment counter, -> CMD.
  - On handshake, otherwise: -> IDLE, clear counter.
- Latency: request accepted at edge E0 -> CMD cycle -> slave samples at E1 -> capture at E2 -> rsp_valid_o high from E2. Minimum 2 cycles request-to-response; 1 further cycle to re-enter IDLE.
- WRITE response: carries the captured slave output, which is 0 by the slave's contract. rsp_adr_o = written address.
- DIRECT response: raw slave output (req_data_i if nonzero, else 64). No substitution in the master.
- rsp_last_o: 1 for every non-DUMP response; for DUMP, 1 only on the address 2**ADR_W-1 response.
- Back-pressure:
  - rsp_ready_i held low stalls in RSP indefinitely; bus stays 00.
  - req_ready_o=0 outside IDLE, so no overlap.
  - A request asserted while busy waits.
- Counter wraps only through the RSP->IDLE clear. There is no address overflow.

Test Plan:
- Reset: hold rst_n_i=0 mid-CMD of a WRITE -> all bus outputs 0 asynchronously, rsp_valid_o=0, req_ready_o=1 after release, no response emitted.
- WRITE adr=2 data=0xA5, then READ adr=2 -> WRITE response data 0x00 adr 2 last=1; READ bus shows {rd,wr}=01 for exactly one cycle, response 0xA5 adr 2, rsp_valid_o 2 cycles after acceptance edge.
- DIRECT data=0x3C -> response 0x3C. DIRECT data=0x00 -> response 0x40 (64). Bus {rd,wr}=11 for one cycle each.
- Write cells 0..3 with 0x11,0x22,0x33,0x44, then DUMP with rsp_ready_i=1 -> four responses: adr 0..3, data 0x11..0x44, rsp_last_o=1 only on the fourth.
- Back-pressure: DUMP with rsp_ready_i low for 5 cycles on the second response -> rsp_data_o stays 0x22, bus remains 00, req_ready_o=0, sequence resumes unchanged.
- Illegal op 3'b110 -> one response with rsp_err_o=1, data 0, last=1, and no bus cycle other than 00.
